// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
//   Groups the stage-facing signals of the pipeline control unit.
//   master : the pipeline (raises stall requests and exceptions, consumes stall/flush/new_pc)
//   slave  : the control unit (pipeline_ctrl)
// Signals
//   stallreq_from_if/id/ex  stall requests from IF, ID, EX
//   excepttype_i            exception type from MEM stage, 0 = none
//   cp0_epc_i               current EPC (eret target)
//   stall[5:0]              [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB, 1 = stop
//   flush                   clear all pipeline registers this cycle
//   new_pc                  redirect target, valid while flush=1
interface pipeline_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Pipeline control unit. Produces the stall vector read by every pipeline register,
//   the flush pulse and redirect PC on exceptions/eret, keeps saturating stall/flush
//   statistics and raises a sticky watchdog flag when a stall is held too long.
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active-low
//   ctrl             pipeline_ctrl_if.slave (requests in, stall/flush/new_pc out)
//   stall_cycles_o   number of cycles with stall != 0 (saturating)
//   flush_count_o    number of flush cycles (saturating)
//   stall_timeout_o  sticky: stall held STALL_TIMEOUT consecutive cycles
// The stall/flush/new_pc outputs are purely combinational from the current requests.
// A pipeline register k inserts a bubble where stall[k]=1 and stall[k+1]=0; the stall
// patterns below are contiguous from bit 0, so exactly one such boundary exists.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   ctrl,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic             stall_timeout_o
);

  localparam int               RUN_W     = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_TIMEOUT - 1);
  localparam logic [31:0]      EXC_ERET  = 32'h0000_000e;

  typedef enum logic [1:0] {ST_RUN, ST_STALLED, ST_FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [5:0]       stall_c;
  logic             flush_c;
  logic [31:0]      new_pc_c;
  logic [RUN_W-1:0] run_len_reg, run_len_next;
  logic             timeout_reg, timeout_hit;
  logic [1:0]       cnt_en;
  logic [CNT_W-1:0] cnt_reg [2];

  // Priority resolver. Outputs are forced quiet while reset is held so the pipeline
  // registers never see a stray stall or flush during reset.
  always_comb begin
    stall_c  = 6'b000000;
    flush_c  = 1'b0;
    new_pc_c = 32'h0;
    if (!rst) begin
      stall_c  = 6'b000000;
    end else if (ctrl.excepttype_i != 32'h0) begin
      // An exception wins over any pending stall; that stall request is dropped.
      flush_c  = 1'b1;
      new_pc_c = (ctrl.excepttype_i == EXC_ERET) ? ctrl.cp0_epc_i : EXC_VECTOR;
    end else if (ctrl.stallreq_from_ex) begin
      stall_c = 6'b001111;
    end else if (ctrl.stallreq_from_id) begin
      stall_c = 6'b000111;
    end else if (ctrl.stallreq_from_if) begin
      stall_c = 6'b000011;
    end
  end

  assign ctrl.stall  = stall_c;
  assign ctrl.flush  = flush_c;
  assign ctrl.new_pc = new_pc_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus the bookkeeping that hangs off it. run_len is only non-zero while
  // the registered state is STALLED, so entering STALLED from RUN/FLUSH starts at 1.
  always_comb begin
    state_next   = ST_RUN;
    cnt_en       = 2'b00;
    run_len_next = '0;
    timeout_hit  = 1'b0;
    if (flush_c) begin
      state_next = ST_FLUSH;
    end else if (stall_c != 6'b000000) begin
      state_next = ST_STALLED;
    end
    case (state_next)
      ST_STALLED: begin
        cnt_en[0] = 1'b1;
        if (state_reg == ST_STALLED) begin
          // Hold at the limit; the sticky flag makes further counting pointless.
          run_len_next = (run_len_reg < RUN_LIMIT) ? run_len_reg + 1'b1 : run_len_reg;
        end else begin
          run_len_next = RUN_W'(1);
        end
        timeout_hit = (run_len_reg == RUN_LIMIT);
      end
      ST_FLUSH: begin
        cnt_en[1] = 1'b1;
      end
      default: begin
        cnt_en = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_len_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      run_len_reg <= run_len_next;
      if (timeout_hit) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  // Saturating statistics counters: [0] stalled cycles, [1] flush cycles.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_en[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cycles_o  = cnt_reg[0];
  assign flush_count_o   = cnt_reg[1];
  assign stall_timeout_o = timeout_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed-vector bench for pipeline_ctrl (STALL_TIMEOUT=8, CNT_W=4). Each step drives
//   one cycle of inputs just after the rising edge and queues the hand-computed response;
//   a monitor on the falling edge pops and compares every field.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] stall_cycles_o;
  logic [3:0] flush_count_o;
  logic       stall_timeout_o;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .STALL_TIMEOUT(8),
    .CNT_W        (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl           (bus),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o),
    .stall_timeout_o(stall_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [3:0]  sc;
    logic [3:0]  fc;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", nm, fld, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      $display("txn %-10s stall=%b flush=%b new_pc=%h sc=%0d fc=%0d to=%b",
               e.name, bus.stall, bus.flush, bus.new_pc, stall_cycles_o, flush_count_o,
               stall_timeout_o);
      chk(e.name, "stall",  {26'h0, bus.stall},      {26'h0, e.stall});
      chk(e.name, "flush",  {31'h0, bus.flush},      {31'h0, e.flush});
      chk(e.name, "new_pc", bus.new_pc,              e.pc);
      chk(e.name, "sc",     {28'h0, stall_cycles_o}, {28'h0, e.sc});
      chk(e.name, "fc",     {28'h0, flush_count_o},  {28'h0, e.fc});
      chk(e.name, "to",     {31'h0, stall_timeout_o}, {31'h0, e.to});
    end
  end

  // One cycle of stimulus: r, if, id, ex, excepttype, epc, then the expected response.
  task automatic step(input string nm, input logic r, input logic i_if, input logic i_id,
                      input logic i_ex, input logic [31:0] exc, input logic [31:0] epc,
                      input logic [5:0] e_stall, input logic e_flush,
                      input logic [31:0] e_pc, input logic [3:0] e_sc,
                      input logic [3:0] e_fc, input logic e_to);
    exp_t e;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.stallreq_from_if = i_if;
    bus.stallreq_from_id = i_id;
    bus.stallreq_from_ex = i_ex;
    bus.excepttype_i     = exc;
    bus.cp0_epc_i        = epc;
    e.name  = nm;
    e.stall = e_stall;
    e.flush = e_flush;
    e.pc    = e_pc;
    e.sc    = e_sc;
    e.fc    = e_fc;
    e.to    = e_to;
    sb_q.push_back(e);
  endtask

  initial begin
    rst                  = 1'b0;
    bus.stallreq_from_if = 1'b0;
    bus.stallreq_from_id = 1'b0;
    bus.stallreq_from_ex = 1'b0;
    bus.excepttype_i     = 32'h0;
    bus.cp0_epc_i        = 32'h0;

    // Reset dominates an EX stall request and a pending exception.
    step("rst_a", 0, 0, 0, 1, 32'h8, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0);
    step("rst_b", 0, 0, 0, 1, 32'h8, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0);
    step("idle0", 1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0);

    // ID-only stall for exactly 3 cycles.
    for (int i = 0; i < 3; i++)
      step("id_stall", 1, 0, 1, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0, 4'(i), 0, 0);
    step("idle1",    1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 3, 0, 0);
    step("id_ex",    1, 0, 1, 1, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 3, 0, 0);
    step("idle2",    1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 4, 0, 0);

    // Exceptions: ov over EX stall, then eret.
    step("exc_ov",   1, 0, 0, 1, 32'hc, 32'h0, 6'b000000, 1, 32'h20, 4, 0, 0);
    step("idle3",    1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 4, 1, 0);
    step("eret",     1, 0, 0, 0, 32'he, 32'h8000_0104, 6'b000000, 1, 32'h8000_0104, 4, 1, 0);
    step("idle4",    1, 0, 0, 0, 32'h0, 32'h8000_0104, 6'b000000, 0, 32'h0, 4, 2, 0);

    // Exception arriving while stalled, then break over an IF request.
    step("ex_stall", 1, 0, 0, 1, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 4, 2, 0);
    step("exc_int",  1, 0, 1, 1, 32'h1, 32'h0, 6'b000000, 1, 32'h20, 5, 2, 0);
    step("exc_brk",  1, 1, 0, 0, 32'h9, 32'h0, 6'b000000, 1, 32'h20, 5, 3, 0);
    step("idle5",    1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 5, 4, 0);

    // Watchdog: 7 cycles is one short, 8 cycles trips it.
    step("rst_c",    0, 0, 0, 1, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      step("if_7", 1, 1, 0, 0, 32'h0, 32'h0, 6'b000011, 0, 32'h0, 4'(i), 0, 0);
    step("idle6",    1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 7, 0, 0);
    step("idle7",    1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 7, 0, 0);
    for (int i = 0; i < 8; i++)
      step("if_8", 1, 1, 0, 0, 32'h0, 32'h0, 6'b000011, 0, 32'h0, 4'(7 + i), 0, 0);
    step("to_set",   1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 15, 0, 1);
    step("to_hold",  1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 15, 0, 1);
    step("rst_mid",  0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0);

    // A flush in the middle of a long stall restarts the watchdog run.
    for (int i = 0; i < 6; i++)
      step("if_pre", 1, 1, 0, 0, 32'h0, 32'h0, 6'b000011, 0, 32'h0, 4'(i), 0, 0);
    step("exc_mid",  1, 1, 0, 0, 32'h1, 32'h0, 6'b000000, 1, 32'h20, 6, 0, 0);
    for (int i = 0; i < 7; i++)
      step("if_post", 1, 1, 0, 0, 32'h0, 32'h0, 6'b000011, 0, 32'h0, 4'(6 + i), 1, 0);
    step("idle8",    1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 13, 1, 0);

    // Saturation of the 4-bit stall counter over a 20-cycle stall.
    step("rst_d",    0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step("sat", 1, 0, 0, 1, 32'h0, 32'h0, 6'b001111, 0, 32'h0,
           (i < 15) ? 4'(i) : 4'hf, 0, (i >= 8) ? 1'b1 : 1'b0);
    step("sat_end",  1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 15, 0, 1);

    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
